// File: rtl/z80_mem_bridge.sv
// z80_mem_bridge: Z80 bus to single-port sync memory bridge (req/ack).
// Optional macro: Z80_BRIDGE_TIMEOUT_EN (REQ timeout, sticky err).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   a, d_out              Z80 address / write data
//   mreq_n, iorq_n, rd_n,
//   wr_n, m1_n, rfsh_n    Z80 strobes (active-low)
//   d_in, wait_n          registered read data / WAIT to the Z80
//   mem_req, mem_we,
//   mem_addr, mem_wdata,
//   mem_fetch             memory request side (all registered)
//   mem_ack, mem_rdata    memory acknowledge / read data
//   err                   sticky timeout flag
module z80_mem_bridge #(
    parameter int ADDR_W     = 16,
    parameter int EXTRA_WAIT = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       a,
    input  logic [7:0]        d_out,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              m1_n,
    input  logic              rfsh_n,
    output logic [7:0]        d_in,
    output logic              wait_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_fetch,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STRETCH,
        HOLD
    } state_t;

    localparam logic [3:0] STR_LAST = 4'(EXTRA_WAIT - 1);

    state_t     state;
    state_t     state_d;
    logic [3:0] scnt;
    logic       abort_q;
    logic       start;
    logic       aborted;
    logic       tmo_hit;
    logic       unused_ok;

    // I/O cycles are rejected by mreq_n alone, so iorq_n is not decoded.
    assign unused_ok = ^{iorq_n, a, TIMEOUT[0]};

    assign start = !mreq_n && rfsh_n && (!rd_n || !wr_n);

    // mreq_n seen high at any REQ edge marks the access as abandoned.
    assign aborted = abort_q || mreq_n;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start)
                    state_d = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    if (aborted)
                        state_d = IDLE;
                    else if (EXTRA_WAIT > 0)
                        state_d = STRETCH;
                    else
                        state_d = HOLD;
                end else if (tmo_hit) begin
                    state_d = HOLD;
                end
            end
            STRETCH: begin
                if (scnt == STR_LAST)
                    state_d = HOLD;
            end
            HOLD: begin
                if (mreq_n)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_n    <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_fetch <= 1'b0;
            d_in      <= '0;
            scnt      <= '0;
            abort_q   <= 1'b0;
        end else begin
            state   <= state_d;
            // Outputs follow the next state so they are registered
            // yet change on the same edge as the state.
            mem_req <= (state_d == REQ);
            wait_n  <= !((state_d == REQ) || (state_d == STRETCH));

            if (state == IDLE && start) begin
                mem_addr  <= a[ADDR_W-1:0];
                mem_we    <= rd_n;
                mem_wdata <= d_out;
                mem_fetch <= ~m1_n;
            end

            if (state == IDLE)
                abort_q <= 1'b0;
            else if (state == REQ && mreq_n)
                abort_q <= 1'b1;

            if (state == REQ && mem_ack && !aborted && !mem_we)
                d_in <= mem_rdata;
            else if (tmo_hit && !mem_we)
                d_in <= 8'hFF;

            if (state == STRETCH)
                scnt <= scnt + 4'd1;
            else
                scnt <= '0;
        end
    end

`ifdef Z80_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tcnt;

    assign tmo_hit = (state == REQ) && !mem_ack
                     && (tcnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            if (state == REQ)
                tcnt <= tcnt + 8'd1;
            else
                tcnt <= '0;
            if (tmo_hit)
                err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_z80_mem_bridge.sv
// tb_z80_mem_bridge: directed self-checking bench for z80_mem_bridge.
// dut0 uses EXTRA_WAIT=0; dut2 uses EXTRA_WAIT=2, TIMEOUT=8.
module tb_z80_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic        mreq0_n, mreq2_n;
    logic        iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic        ack0, ack2;
    logic [7:0]  rdata;

    logic [7:0]  din0, din2;
    logic        wait0, wait2, req0, req2, we0, we2;
    logic [15:0] addr0, addr2;
    logic [7:0]  wdata0, wdata2;
    logic        fetch0, fetch2, err0, err2;

    int checks = 0;
    int errors = 0;
    int wlo0 = 0, wlo2 = 0, rq0 = 0, rq2 = 0;
    logic prq0 = 1'b0, prq2 = 1'b0;
    int bw, br;

    always #5 clk = ~clk;

    z80_mem_bridge #(.ADDR_W(16), .EXTRA_WAIT(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .d_out(d_out),
        .mreq_n(mreq0_n), .iorq_n(iorq_n), .rd_n(rd_n),
        .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .d_in(din0), .wait_n(wait0), .mem_req(req0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_fetch(fetch0), .mem_ack(ack0), .mem_rdata(rdata),
        .err(err0)
    );

    z80_mem_bridge #(.ADDR_W(16), .EXTRA_WAIT(2), .TIMEOUT(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .d_out(d_out),
        .mreq_n(mreq2_n), .iorq_n(iorq_n), .rd_n(rd_n),
        .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .d_in(din2), .wait_n(wait2), .mem_req(req2),
        .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .mem_fetch(fetch2), .mem_ack(ack2), .mem_rdata(rdata),
        .err(err2)
    );

    // Count WAIT-low cycles and mem_req rising edges per DUT.
    always @(negedge clk) begin
        if (!wait0) wlo0 <= wlo0 + 1;
        if (!wait2) wlo2 <= wlo2 + 1;
        if (req0 && !prq0) rq0 <= rq0 + 1;
        if (req2 && !prq2) rq2 <= rq2 + 1;
        prq0 <= req0;
        prq2 <= req2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        mreq0_n = 1'b1; mreq2_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic test_reset;
        a = '0; d_out = '0; rdata = '0; ack0 = 1'b0; ack2 = 1'b0;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({wait0, req0, we0, fetch0, err0} !== 5'b10000) begin
            errors++;
            $display("FAIL rst_ctl0: got %b want 10000",
                     {wait0, req0, we0, fetch0, err0});
        end
        checks++;
        if ({addr0, wdata0, din0} !== 32'h0) begin
            errors++;
            $display("FAIL rst_data0: got %h want 0",
                     {addr0, wdata0, din0});
        end
        checks++;
        if ({wait2, req2, we2, fetch2, err2} !== 5'b10000) begin
            errors++;
            $display("FAIL rst_ctl2: got %b want 10000",
                     {wait2, req2, we2, fetch2, err2});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_fetch;
        bw = wlo0; br = rq0;
        a = 16'h0001; m1_n = 1'b0; rd_n = 1'b0; mreq0_n = 1'b0;
        rdata = 8'h3E; ack0 = 1'b1;
        tick();
        checks++;
        if ({req0, wait0, we0, fetch0} !== 4'b1001) begin
            errors++;
            $display("FAIL rd_start: got %b want 1001",
                     {req0, wait0, we0, fetch0});
        end
        checks++;
        if (addr0 !== 16'h0001) begin
            errors++;
            $display("FAIL rd_addr: got %h want 0001", addr0);
        end
        tick();
        checks++;
        if ({req0, wait0, din0} !== {2'b01, 8'h3E}) begin
            errors++;
            $display("FAIL rd_done: got %b/%b/%h want 0/1/3e",
                     req0, wait0, din0);
        end
        ack0 = 1'b0;
        bus_idle();
        repeat (2) tick();
        checks++;
        if ((wlo0 - bw) != 1 || (rq0 - br) != 1) begin
            errors++;
            $display("FAIL rd_counts: wait %0d req %0d want 1 1",
                     wlo0 - bw, rq0 - br);
        end
    endtask

    task automatic test_write_delayed;
        bw = wlo0; br = rq0;
        rdata = 8'h55; a = 16'hAA20; d_out = 8'h1D;
        wr_n = 1'b0; mreq0_n = 1'b0;
        tick();
        checks++;
        if ({req0, wait0, we0, fetch0} !== 4'b1010) begin
            errors++;
            $display("FAIL wr_start: got %b want 1010",
                     {req0, wait0, we0, fetch0});
        end
        checks++;
        if (addr0 !== 16'hAA20 || wdata0 !== 8'h1D) begin
            errors++;
            $display("FAIL wr_latch: got %h/%h want aa20/1d",
                     addr0, wdata0);
        end
        repeat (2) tick();
        checks++;
        if ({req0, wait0} !== 2'b10) begin
            errors++;
            $display("FAIL wr_wait: got %b want 10", {req0, wait0});
        end
        ack0 = 1'b1;
        tick();
        checks++;
        if ({req0, wait0, din0} !== {2'b01, 8'h3E}) begin
            errors++;
            $display("FAIL wr_done: got %b/%b/%h want 0/1/3e",
                     req0, wait0, din0);
        end
        ack0 = 1'b0;
        bus_idle();
        repeat (2) tick();
        checks++;
        if ((wlo0 - bw) != 3 || (rq0 - br) != 1) begin
            errors++;
            $display("FAIL wr_counts: wait %0d req %0d want 3 1",
                     wlo0 - bw, rq0 - br);
        end
        checks++;
        if (addr0 !== 16'hAA20 || we0 !== 1'b1) begin
            errors++;
            $display("FAIL wr_stable: got %h/%b want aa20/1",
                     addr0, we0);
        end
    endtask

    task automatic test_filter;
        bw = wlo0; br = rq0;
        mreq0_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({req0, wait0} !== 2'b01) begin
                errors++;
                $display("FAIL rfsh_%0d: got %b want 01",
                         i, {req0, wait0});
            end
        end
        mreq0_n = 1'b1; rfsh_n = 1'b1; iorq_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({req0, wait0} !== 2'b01) begin
                errors++;
                $display("FAIL io_%0d: got %b want 01",
                         i, {req0, wait0});
            end
        end
        bus_idle();
        tick();
        checks++;
        if ((wlo0 - bw) != 0 || (rq0 - br) != 0) begin
            errors++;
            $display("FAIL filt_counts: wait %0d req %0d want 0 0",
                     wlo0 - bw, rq0 - br);
        end
    endtask

    task automatic test_violation;
        rdata = 8'hAB; a = 16'h0100; rd_n = 1'b0; mreq0_n = 1'b0;
        tick();
        mreq0_n = 1'b1; rd_n = 1'b1;
        tick();
        checks++;
        if ({req0, wait0} !== 2'b10) begin
            errors++;
            $display("FAIL viol_hold: got %b want 10", {req0, wait0});
        end
        ack0 = 1'b1;
        tick();
        checks++;
        if ({req0, wait0, din0} !== {2'b01, 8'h3E}) begin
            errors++;
            $display("FAIL viol_drop: got %b/%b/%h want 0/1/3e",
                     req0, wait0, din0);
        end
        ack0 = 1'b0; a = 16'h0200; rd_n = 1'b0; mreq0_n = 1'b0;
        tick();
        checks++;
        if (req0 !== 1'b1 || addr0 !== 16'h0200) begin
            errors++;
            $display("FAIL viol_idle: got %b/%h want 1/0200",
                     req0, addr0);
        end
        rdata = 8'h77; ack0 = 1'b1;
        tick();
        checks++;
        if (din0 !== 8'h77) begin
            errors++;
            $display("FAIL viol_next: got %h want 77", din0);
        end
        ack0 = 1'b0;
        bus_idle();
        repeat (2) tick();
    endtask

    task automatic test_stretch_hold;
        bw = wlo2; br = rq2;
        a = 16'h1234; rd_n = 1'b0; mreq2_n = 1'b0;
        rdata = 8'h5A; ack2 = 1'b1;
        tick();
        checks++;
        if ({req2, wait2} !== 2'b10) begin
            errors++;
            $display("FAIL st_req: got %b want 10", {req2, wait2});
        end
        tick();
        checks++;
        if ({req2, wait2, din2} !== {2'b00, 8'h5A}) begin
            errors++;
            $display("FAIL st_ack: got %b/%b/%h want 0/0/5a",
                     req2, wait2, din2);
        end
        tick();
        checks++;
        if ({req2, wait2} !== 2'b00) begin
            errors++;
            $display("FAIL st_str: got %b want 00", {req2, wait2});
        end
        tick();
        checks++;
        if ({req2, wait2} !== 2'b01) begin
            errors++;
            $display("FAIL st_rel: got %b want 01", {req2, wait2});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({req2, wait2} !== 2'b01) begin
                errors++;
                $display("FAIL st_hold_%0d: got %b want 01",
                         i, {req2, wait2});
            end
        end
        checks++;
        if ((wlo2 - bw) != 3 || (rq2 - br) != 1) begin
            errors++;
            $display("FAIL st_counts: wait %0d req %0d want 3 1",
                     wlo2 - bw, rq2 - br);
        end
        mreq2_n = 1'b1; rd_n = 1'b1;
        tick();
        rdata = 8'hC3; a = 16'h4321; rd_n = 1'b0; mreq2_n = 1'b0;
        tick();
        checks++;
        if (req2 !== 1'b1 || addr2 !== 16'h4321) begin
            errors++;
            $display("FAIL st_again: got %b/%h want 1/4321",
                     req2, addr2);
        end
        tick();
        checks++;
        if (din2 !== 8'hC3) begin
            errors++;
            $display("FAIL st_again_d: got %h want c3", din2);
        end
        repeat (2) tick();
        ack2 = 1'b0;
        bus_idle();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid;
        rdata = 8'h99; a = 16'h0F0F; rd_n = 1'b0; mreq0_n = 1'b0;
        ack0 = 1'b0;
        tick();
        checks++;
        if ({req0, wait0} !== 2'b10) begin
            errors++;
            $display("FAIL rm_req: got %b want 10", {req0, wait0});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req0, wait0, din0, addr0} !== {2'b01, 8'h00, 16'h0}) begin
            errors++;
            $display("FAIL rm_async: got %b/%b/%h/%h want 0/1/00/0000",
                     req0, wait0, din0, addr0);
        end
        bus_idle();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout;
`ifdef Z80_BRIDGE_TIMEOUT_EN
        rdata = 8'h12; a = 16'h0042; rd_n = 1'b0; mreq2_n = 1'b0;
        ack2 = 1'b0;
        tick();
        repeat (7) tick();
        checks++;
        if ({req2, wait2, err2} !== 3'b100) begin
            errors++;
            $display("FAIL to_wait: got %b want 100",
                     {req2, wait2, err2});
        end
        tick();
        checks++;
        if ({req2, wait2, err2, din2} !== {3'b011, 8'hFF}) begin
            errors++;
            $display("FAIL to_fire: got %b/%h want 011/ff",
                     {req2, wait2, err2}, din2);
        end
        bus_idle();
        repeat (2) tick();
        rdata = 8'h34; rd_n = 1'b0; mreq2_n = 1'b0; ack2 = 1'b1;
        repeat (2) tick();
        checks++;
        if (din2 !== 8'h34 || err2 !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: got %h/%b want 34/1",
                     din2, err2);
        end
        repeat (2) tick();
        ack2 = 1'b0;
        bus_idle();
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (err2 !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: got %b want 0", err2);
        end
        tick();
        rst_n = 1'b1;
        tick();
`else
        checks++;
        if ({err0, err2} !== 2'b00) begin
            errors++;
            $display("FAIL err_tied: got %b want 00", {err0, err2});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_read_fetch();
        test_write_delayed();
        test_filter();
        test_violation();
        test_stretch_hold();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_mem_bridge.md
# z80_mem_bridge

Bridges the Z80 core's external memory bus to a generic single-port synchronous memory with a level req/ack handshake. It sits directly downstream of the Z80 core in the user project, between the core's bus pins and the on-chip memory. It decodes Z80 memory read and write cycles and ignores refresh and I/O cycles. It holds the CPU with `wait_n` until the memory acknowledges, then presents read data on `d_in`.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width. The bridge forwards the low `ADDR_W` bits of the Z80 address.
- `EXTRA_WAIT`, default 0: extra cycles `wait_n` stays low after `mem_ack` (0–15).
- `TIMEOUT`, default 255: cycles to wait for `mem_ack` before aborting. Used only with the macro in Configuration.

Ports:
- `clk` in 1: system clock. This is the same clock as the Z80 core.
- `rst_n` in 1: asynchronous, active-low reset.
- `a` in 16: Z80 address bus.
- `d_out` in 8: Z80 data out, used for writes.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfsh_n` in 1 each: Z80 bus strobes, all active-low.
- `d_in` out 8: registered read data to the Z80.
- `wait_n` out 1: Z80 WAIT input, active-low.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out `ADDR_W`: latched address.
- `mem_wdata` out 8: latched write data.
- `mem_fetch` out 1: 1 when the current access is an M1 opcode fetch.
- `mem_ack` in 1: memory acknowledge.
- `mem_rdata` in 8: read data, valid when `mem_ack`=1.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, STRETCH, HOLD.
- IDLE:
  - A cycle starts when `mreq_n`=0, `rfsh_n`=1 and (`rd_n`=0 or `wr_n`=0) are sampled together.
  - On that edge: latch `mem_addr`=`a[ADDR_W-1:0]`, `mem_we`=(`rd_n`=1), `mem_wdata`=`d_out`, `mem_fetch`=~`m1_n`. Then go to REQ.
  - If `rd_n` and `wr_n` are both low, the access is a read (`mem_we`=0).
- REQ:
  - `mem_req`=1, `wait_n`=0.
  - On `mem_ack`=1: capture `d_in`=`mem_rdata` (reads only; `d_in` is unchanged on writes) and drop `mem_req`.
  - Next state is STRETCH if `EXTRA_WAIT`>0, otherwise HOLD.
- STRETCH: `wait_n`=0 for `EXTRA_WAIT` cycles, counted by a 4-bit counter. Then go to HOLD.
- HOLD:
  - `wait_n`=1, `mem_req`=0.
  - Stay until `mreq_n`=1 is sampled, then go to IDLE. This guarantees one memory access per Z80 machine cycle.
- Refresh (`rfsh_n`=0) and I/O (`iorq_n`=0 with `mreq_n`=1) cycles never leave IDLE, and `wait_n` stays 1 during them.
- If `mreq_n` rises while in REQ (protocol violation):
  - `mem_req` is still held until `mem_ack`.
  - Read data is discarded and `d_in` is unchanged.
  - The FSM then goes directly to IDLE.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_fetch` stay stable from entry to REQ until the next IDLE start.

## Timing
- Reset values:
  - State IDLE.
  - `wait_n`=1, `mem_req`=0, `mem_we`=0.
  - `mem_addr`=0, `mem_wdata`=0, `mem_fetch`=0.
  - `d_in`=0, `err`=0.
- All outputs are registered.
- Start is sampled at edge N. `mem_req`=1 and `wait_n`=0 are visible after edge N.
- If `mem_ack` is sampled at edge N+k:
  - `d_in` is valid after N+k.
  - `mem_req`=0 after N+k.
  - `wait_n`=1 after N+k+`EXTRA_WAIT`.
- Minimum stall: with `mem_ack` on the first REQ cycle and `EXTRA_WAIT`=0, `wait_n` is low for exactly one cycle.
- `mem_ack` is ignored outside REQ.
- Asserting `rst_n` mid-cycle immediately returns every output to its reset value. Any outstanding request is abandoned, and the memory must tolerate a dropped `mem_req`.

## Configuration
- `Z80_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit counter runs in REQ.
  - If `mem_ack` has not arrived after `TIMEOUT` cycles, the bridge drops `mem_req`, loads `d_in`=8'hFF (reads only), sets `err`=1 and goes to HOLD.
  - `err` is cleared only by reset.
- `Z80_BRIDGE_TIMEOUT_EN` undefined: REQ waits for `mem_ack` indefinitely, `err` is tied to 0, and the counter is not synthesised.

## Test plan
- Read, immediate ack: opcode fetch at `a`=16'h0001 with `m1_n`=0 and `mem_rdata`=8'h3E, ack on the first REQ cycle.
  - Expect `mem_addr`=1, `mem_fetch`=1, `wait_n` low for 1 cycle, `d_in`=8'h3E, exactly one `mem_req` pulse.
- Write, delayed ack: `a`=16'hAA20, `d_out`=8'h1D, ack after 3 cycles.
  - Expect `mem_we`=1, `mem_wdata`=8'h1D, `wait_n` low for 3 cycles, `d_in` unchanged.
- Refresh and I/O filtering: `mreq_n`=0 with `rfsh_n`=0, then an I/O read with `iorq_n`=0.
  - Expect `mem_req`=0 and `wait_n`=1 throughout.
- Stretch and hold: `EXTRA_WAIT`=2, immediate ack, `mreq_n` held low for 4 extra cycles.
  - Expect `wait_n` low for 3 cycles, a single request, and no new request until `mreq_n` has been high once.
- Reset mid-cycle: assert `rst_n`=0 during REQ.
  - Expect `mem_req`=0, `wait_n`=1 and `d_in`=0 immediately, without a clock edge.
- Timeout (macro on, `TIMEOUT`=8): read with no ack.
  - Expect `mem_req` dropped after 8 REQ cycles, `d_in`=8'hFF, `err`=1.
  - Expect `err` to persist through the next normal access until reset.
